// File: rtl/sum_cond_watcher.sv
// sum_cond_watcher
//   Hardware evaluator for the event control @(a + b == target). Once armed,
//   the first op_valid cycle records the condition as a baseline. A later
//   change of the condition (any change, or false->true only) produces a
//   one-cycle hit pulse together with the level and sum that caused it.
//
//   Optional feature macro: SUM_COND_WATCHER_TIMEOUT_EN
//     defined   - a cycle budget (arm_timeout, 0 = none) aborts the wait and
//                 pulses timeout
//     undefined - no counter is built, timeout is tied low
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   arm_valid/ready   arm handshake; arm_ready is high only in IDLE
//   arm_target        target sum, captured on the arm handshake
//   arm_mode          0 = any condition change, 1 = rising only
//   arm_timeout       cycle budget (used only with the timeout feature)
//   cancel            silently abort an armed wait
//   op_valid/a/b      per-cycle operands from the upstream counter stage
//   hit               one-cycle trigger pulse
//   hit_level/sum     condition value and sum of the last hit (held)
//   timeout           one-cycle expiry pulse
//   busy              high while armed (SAMPLE or WAIT)
module sum_cond_watcher #(
  parameter int WIDTH = 32,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_valid,
  output logic             arm_ready,
  input  logic [WIDTH-1:0] arm_target,
  input  logic             arm_mode,
  input  logic [TMO_W-1:0] arm_timeout,
  input  logic             cancel,
  input  logic             op_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             hit,
  output logic             hit_level,
  output logic [WIDTH-1:0] hit_sum,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SAMPLE, WAIT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] target_reg;
  logic             mode_reg;
  logic             prev_reg;
  logic             hit_reg;
  logic             hit_level_reg;
  logic [WIDTH-1:0] hit_sum_reg;
  logic             timeout_reg;

  // Carry is discarded: the sum wraps modulo 2^WIDTH.
  logic [WIDTH-1:0] sum;
  logic             cond;
  logic             trigger;

  assign sum  = op_a + op_b;
  assign cond = (sum == target_reg);

  // Only WAIT can trigger; the SAMPLE cycle only establishes the baseline.
  assign trigger = (state_reg == WAIT) && op_valid &&
                   (mode_reg ? (cond && !prev_reg) : (cond != prev_reg));

`ifdef SUM_COND_WATCHER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_reg;
`else
  // Budget input has no function without the counter.
  logic unused_timeout;
  assign unused_timeout = ^arm_timeout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      target_reg    <= '0;
      mode_reg      <= 1'b0;
      prev_reg      <= 1'b0;
      hit_reg       <= 1'b0;
      hit_level_reg <= 1'b0;
      hit_sum_reg   <= '0;
      timeout_reg   <= 1'b0;
`ifdef SUM_COND_WATCHER_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
`endif
    end else begin
      // Pulses default low so they last exactly one cycle.
      hit_reg     <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (arm_valid) begin
            target_reg <= arm_target;
            mode_reg   <= arm_mode;
            state_reg  <= SAMPLE;
`ifdef SUM_COND_WATCHER_TIMEOUT_EN
            tmo_cnt_reg <= arm_timeout;
`endif
          end
        end
        SAMPLE, WAIT: begin
          if (cancel) begin
            // Cancel beats both trigger and expiry.
            state_reg <= IDLE;
          end else if (trigger) begin
            // Trigger beats an expiry on the same edge.
            state_reg     <= IDLE;
            hit_reg       <= 1'b1;
            hit_level_reg <= cond;
            hit_sum_reg   <= sum;
          end else begin
            if (op_valid) begin
              prev_reg  <= cond;
              state_reg <= WAIT;
            end
`ifdef SUM_COND_WATCHER_TIMEOUT_EN
            // A zero count means no budget; the counter then stays at zero.
            if (tmo_cnt_reg != '0) begin
              tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
              if (tmo_cnt_reg == TMO_W'(1)) begin
                state_reg   <= IDLE;
                timeout_reg <= 1'b1;
              end
            end
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign arm_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign hit       = hit_reg;
  assign hit_level = hit_level_reg;
  assign hit_sum   = hit_sum_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_sum_cond_watcher.sv
module tb_sum_cond_watcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm_valid, arm_ready, arm_mode, cancel, op_valid;
  logic [31:0] arm_target, op_a, op_b, hit_sum;
  logic [15:0] arm_timeout;
  logic        hit, hit_level, timeout, busy;

  // Narrow instance for the wrap-around case.
  logic        arm_valid8, arm_ready8, arm_mode8, cancel8, op_valid8;
  logic [7:0]  arm_target8, op_a8, op_b8, hit_sum8;
  logic [15:0] arm_timeout8;
  logic        hit8, hit_level8, timeout8, busy8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_cond_watcher #(.WIDTH(32), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .arm_valid(arm_valid), .arm_ready(arm_ready),
    .arm_target(arm_target), .arm_mode(arm_mode), .arm_timeout(arm_timeout),
    .cancel(cancel), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .hit(hit), .hit_level(hit_level), .hit_sum(hit_sum),
    .timeout(timeout), .busy(busy));

  sum_cond_watcher #(.WIDTH(8), .TMO_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .arm_valid(arm_valid8), .arm_ready(arm_ready8),
    .arm_target(arm_target8), .arm_mode(arm_mode8), .arm_timeout(arm_timeout8),
    .cancel(cancel8), .op_valid(op_valid8), .op_a(op_a8), .op_b(op_b8),
    .hit(hit8), .hit_level(hit_level8), .hit_sum(hit_sum8),
    .timeout(timeout8), .busy(busy8));

  typedef struct {
    logic        arm;
    logic [31:0] tgt;
    logic        mode;
    logic        cncl;
    logic        opv;
    logic [31:0] a;
    logic [31:0] b;
    logic        ehit;
    logic        elev;
    logic [31:0] esum;
    logic        ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic arm, logic [31:0] tgt, logic mode, logic cncl,
                              logic opv, logic [31:0] a, logic [31:0] b,
                              logic ehit, logic elev, logic [31:0] esum, logic ebusy);
    vec_t v;
    v.arm = arm; v.tgt = tgt; v.mode = mode; v.cncl = cncl; v.opv = opv;
    v.a = a; v.b = b; v.ehit = ehit; v.elev = elev; v.esum = esum; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm_valid = 0; arm_target = 0; arm_mode = 0; arm_timeout = 0;
    cancel = 0; op_valid = 0; op_a = 0; op_b = 0;
  endtask

  // Reference model state: armed / baseline-taken flags plus the held outputs.
  bit          m_armed, m_based, m_prev, m_mode, m_hit, m_tmo, m_level;
  logic [31:0] m_tgt, m_sum;
  int          m_left;

  task automatic model_reset();
    m_armed = 0; m_based = 0; m_prev = 0; m_mode = 0; m_hit = 0; m_tmo = 0;
    m_level = 0; m_tgt = 0; m_sum = 0; m_left = 0;
  endtask

  task automatic model_step();
    logic [31:0] s;
    bit c, trig;
    m_hit = 0; m_tmo = 0;
    if (!m_armed) begin
      if (arm_valid) begin
        m_armed = 1; m_based = 0; m_tgt = arm_target; m_mode = arm_mode;
`ifdef SUM_COND_WATCHER_TIMEOUT_EN
        m_left = int'(arm_timeout);
`else
        m_left = 0;
`endif
      end
    end else if (cancel) begin
      m_armed = 0;
    end else begin
      s = op_a + op_b;
      c = (s == m_tgt);
      trig = 0;
      if (op_valid) begin
        if (m_based) trig = m_mode ? (c && !m_prev) : (c != m_prev);
        m_prev = c;
        m_based = 1;
      end
      if (trig) begin
        m_armed = 0; m_hit = 1; m_level = c; m_sum = s;
      end else if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_armed = 0; m_tmo = 1;
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    arm_valid8 = 0; arm_target8 = 0; arm_mode8 = 0; arm_timeout8 = 0;
    cancel8 = 0; op_valid8 = 0; op_a8 = 0; op_b8 = 0;
    rst_n = 0;
    #12;
    check("reset_hit", {31'd0, hit}, 0);
    check("reset_hit_level", {31'd0, hit_level}, 0);
    check("reset_hit_sum", hit_sum, 0);
    check("reset_timeout", {31'd0, timeout}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_arm_ready", {31'd0, arm_ready}, 1);
    rst_n = 1;
    tick();

    //           arm tgt mode cncl opv a   b  | hit lev sum busy
    tbl.push_back(mk(1, 12, 0, 0, 0, 0,  0,    0, 0, 0,  1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 8,  4,    0, 0, 0,  1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 9,  6,    1, 0, 15, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0,    0, 0, 15, 0));
    tbl.push_back(mk(1, 24, 1, 0, 0, 0,  0,    0, 0, 15, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 8,  4,    0, 0, 15, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 9,  6,    0, 0, 15, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 10, 8,    0, 0, 15, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 11, 10,   0, 0, 15, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 12, 12,   1, 1, 24, 0));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0,    0, 1, 24, 0));
    tbl.push_back(mk(1, 5,  0, 0, 0, 0,  0,    0, 1, 24, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 2,  3,    0, 1, 24, 1));
    tbl.push_back(mk(0, 0,  0, 1, 1, 1,  1,    0, 1, 24, 0));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0,    0, 1, 24, 0));
    tbl.push_back(mk(1, 10, 1, 0, 0, 0,  0,    0, 1, 24, 1));
    tbl.push_back(mk(0, 0,  0, 0, 0, 0,  0,    0, 1, 24, 1));
    tbl.push_back(mk(1, 7,  0, 0, 1, 3,  3,    0, 1, 24, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 3,  4,    0, 1, 24, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 5,  5,    1, 1, 10, 0));
    tbl.push_back(mk(1, 3,  0, 0, 0, 0,  0,    0, 1, 10, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 1,  2,    0, 1, 10, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 1,  2,    0, 1, 10, 1));
    tbl.push_back(mk(0, 0,  0, 0, 1, 0,  0,    1, 0, 0,  0));

    for (int i = 0; i < tbl.size(); i++) begin
      arm_valid = tbl[i].arm; arm_target = tbl[i].tgt; arm_mode = tbl[i].mode;
      cancel = tbl[i].cncl; op_valid = tbl[i].opv; op_a = tbl[i].a; op_b = tbl[i].b;
      arm_timeout = 0;
      tick();
      check($sformatf("tbl%0d_hit", i), {31'd0, hit}, {31'd0, tbl[i].ehit});
      check($sformatf("tbl%0d_level", i), {31'd0, hit_level}, {31'd0, tbl[i].elev});
      check($sformatf("tbl%0d_sum", i), hit_sum, tbl[i].esum);
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].ebusy});
      check($sformatf("tbl%0d_ready", i), {31'd0, arm_ready}, {31'd0, !tbl[i].ebusy});
      check($sformatf("tbl%0d_timeout", i), {31'd0, timeout}, 0);
    end
    idle_inputs();

    // Wrapped sum on the 8-bit instance: 250 + 10 = 260 -> 4.
    arm_valid8 = 1; arm_target8 = 4; arm_mode8 = 1;
    tick();
    arm_valid8 = 0; op_valid8 = 1; op_a8 = 0; op_b8 = 0;
    tick();
    check("w8_busy_after_base", {31'd0, busy8}, 1);
    check("w8_no_hit_base", {31'd0, hit8}, 0);
    op_a8 = 250; op_b8 = 10;
    tick();
    op_valid8 = 0;
    check("w8_hit", {31'd0, hit8}, 1);
    check("w8_hit_sum", {24'd0, hit_sum8}, 4);
    check("w8_hit_level", {31'd0, hit_level8}, 1);

    // Reset mid-WAIT: first leave a nonzero hit_sum behind.
    arm_valid = 1; arm_target = 6; arm_mode = 0;
    tick();
    arm_valid = 0; op_valid = 1; op_a = 3; op_b = 3;
    tick();
    op_a = 1; op_b = 1;
    tick();
    check("pre_rst_hit_sum", hit_sum, 2);
    op_valid = 0; arm_valid = 1; arm_target = 50;
    tick();
    arm_valid = 0; op_valid = 1; op_a = 1; op_b = 1;
    tick();
    tick();
    op_valid = 0;
    #2 rst_n = 0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_ready", {31'd0, arm_ready}, 1);
    check("async_rst_hit_sum", hit_sum, 0);
    check("async_rst_hit", {31'd0, hit}, 0);
    #1 rst_n = 1;
    tick();
    arm_valid = 1; arm_target = 9; arm_mode = 1;
    tick();
    check("rearm_busy", {31'd0, busy}, 1);
    arm_valid = 0; op_valid = 1; op_a = 4; op_b = 4;
    tick();
    op_b = 5;
    tick();
    op_valid = 0;
    check("rearm_hit", {31'd0, hit}, 1);
    check("rearm_hit_sum", hit_sum, 9);
    idle_inputs();
    tick();

`ifdef SUM_COND_WATCHER_TIMEOUT_EN
    // Plain expiry: timeout pulse on the 5th edge after the arm edge.
    arm_valid = 1; arm_target = 100; arm_mode = 0; arm_timeout = 5;
    tick();
    arm_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("tmo_wait%0d_timeout", k), {31'd0, timeout}, 0);
      check($sformatf("tmo_wait%0d_busy", k), {31'd0, busy}, 1);
    end
    tick();
    check("tmo_pulse", {31'd0, timeout}, 1);
    check("tmo_ready", {31'd0, arm_ready}, 1);
    tick();
    check("tmo_pulse_end", {31'd0, timeout}, 0);
    // Trigger on the expiry edge wins.
    arm_valid = 1; arm_target = 0; arm_timeout = 5;
    tick();
    arm_valid = 0; op_valid = 1; op_a = 0; op_b = 0;
    tick();
    op_valid = 0;
    tick(); tick(); tick();
    check("tmo_race_busy", {31'd0, busy}, 1);
    op_valid = 1; op_a = 1;
    tick();
    op_valid = 0;
    check("tmo_race_hit", {31'd0, hit}, 1);
    check("tmo_race_timeout", {31'd0, timeout}, 0);
    idle_inputs();
    tick();
`endif

    // Randomized run against the reference model.
    rst_n = 0;
    #3 rst_n = 1;
    model_reset();
    tick();
    for (int n = 0; n < 600; n++) begin
      arm_valid   = ($urandom_range(0, 3) == 0);
      arm_target  = $urandom_range(0, 14);
      arm_mode    = $urandom_range(0, 1);
      arm_timeout = 16'($urandom_range(0, 12));
      cancel      = ($urandom_range(0, 15) == 0);
      op_valid    = ($urandom_range(0, 3) != 0);
      op_a        = $urandom_range(0, 7);
      op_b        = $urandom_range(0, 7);
      tick();
      model_step();
      check("rnd_hit", {31'd0, hit}, {31'd0, m_hit});
      check("rnd_level", {31'd0, hit_level}, {31'd0, m_level});
      check("rnd_sum", hit_sum, m_sum);
      check("rnd_timeout", {31'd0, timeout}, {31'd0, m_tmo});
      check("rnd_busy", {31'd0, busy}, {31'd0, m_armed});
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
